vmask_expand: RTL and testbench

Count-to-mask expander: takes a scalar element count N and emits a stream of mask words in which bits 0..N-1 (across the whole stream) are set and all later bits are clear. It is the inverse of the vALU population-count reduction (mask stream in, scalar out). It feeds the mask write-back path and supplies vl/tail-derived masks (for example, vmset-style fills limited to vl) to the vector register file.

---
 rtl/vmask_pkg.sv | 17 +
 rtl/vmask_word_fill.sv | 24 ++
 rtl/vmask_expand.sv | 129 ++++++++++++
 tb/tb_vmask_expand.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vmask_pkg.sv
// Shared types and helpers for the vector mask expansion units.
package vmask_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int LOG2_DW        = $clog2(DEF_DATA_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Subtract b from a, clamping at zero instead of wrapping.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/vmask_word_fill.sv
// Thermometer word generator: the low `rem` bits set, saturating to all ones.
module vmask_word_fill #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic [CNT_WIDTH-1:0]  rem,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int SHW = $clog2(DATA_WIDTH);

    // DATA_WIDTH is a power of two, so any bit at or above SHW means rem >= DATA_WIDTH.
    logic saturate;
    assign saturate = |rem[CNT_WIDTH-1:SHW];

    always_comb begin
        if (saturate) begin
            word = '1;
        end else begin
            word = ~({DATA_WIDTH{1'b1}} << rem[SHW-1:0]);
        end
    end

endmodule

// File: rtl/vmask_expand.sv
// Count-to-mask expander: turns a scalar count N into a stream of mask words
// with bits 0..N-1 set across the stream.
module vmask_expand
    import vmask_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CNT_WIDTH-1:0]  in_count,
    input  logic [CNT_WIDTH-1:0]  in_nwords,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_vec,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    output logic                  out_end
);

    state_e                  state_q, state_d;
    // rem_q and addr_q describe the word after the one in the output registers;
    // words_left_q counts the output-register word too.
    logic [CNT_WIDTH-1:0]    rem_q, rem_d;
    logic [CNT_WIDTH-1:0]    words_left_q, words_left_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   out_vec_q, out_vec_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_end_q, out_end_d;

    logic                    accept;
    logic                    handshake;
    logic [CNT_WIDTH-1:0]    fill_rem;
    logic [DATA_WIDTH-1:0]   fill_word;
    logic [CNT_WIDTH-1:0]    first_words;

    assign in_ready    = (state_q == IDLE) && !rst;
    assign accept      = in_valid && in_ready;
    assign handshake   = out_valid_q && out_ready;
    assign first_words = (in_nwords == '0) ? CNT_WIDTH'(1) : in_nwords;
    assign fill_rem    = (state_q == IDLE) ? in_count : rem_q;

    vmask_word_fill #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fill (
        .rem  (fill_rem),
        .word (fill_word)
    );

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        out_vec_d    = out_vec_q;
        out_addr_d   = out_addr_q;
        out_valid_d  = out_valid_q;
        out_end_d    = out_end_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EMIT;
                    out_vec_d    = fill_word;
                    out_addr_d   = in_addr;
                    out_valid_d  = 1'b1;
                    out_end_d    = (first_words == CNT_WIDTH'(1));
                    words_left_d = first_words;
                    rem_d        = CNT_WIDTH'(sat_sub(32'(in_count), 32'(DATA_WIDTH)));
                    addr_d       = in_addr + ADDR_WIDTH'(1);
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (out_end_q) begin
                        state_d     = IDLE;
                        out_vec_d   = '0;
                        out_addr_d  = '0;
                        out_valid_d = 1'b0;
                        out_end_d   = 1'b0;
                    end else begin
                        out_vec_d    = fill_word;
                        out_addr_d   = addr_q;
                        out_end_d    = (words_left_q == CNT_WIDTH'(2));
                        words_left_d = words_left_q - CNT_WIDTH'(1);
                        rem_d        = CNT_WIDTH'(sat_sub(32'(rem_q), 32'(DATA_WIDTH)));
                        addr_d       = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
            out_vec_q    <= '0;
            out_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            out_end_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            out_vec_q    <= out_vec_d;
            out_addr_q   <= out_addr_d;
            out_valid_q  <= out_valid_d;
            out_end_q    <= out_end_d;
        end
    end

    assign out_vec   = out_vec_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign out_end   = out_end_q;

endmodule

// File: tb/tb_vmask_expand.sv
// Directed bench for vmask_expand: vector table plus hand-written corner sequences.
module tb_vmask_expand;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [15:0]      count;
        logic [15:0]      nwords;
        logic [31:0]      addr;
        logic [2:0]       n;
        logic [2:0][63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_count;
    logic [15:0] in_nwords;
    logic [31:0] in_addr;
    logic        out_ready;
    logic [63:0] out_vec;
    logic [31:0] out_addr;
    logic        out_valid;
    logic        out_end;

    int errors = 0;
    int checks = 0;

    vmask_expand dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .in_nwords (in_nwords),
        .in_addr   (in_addr),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_end   (out_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [63:0] vec,
                              input logic [31:0] addr, input logic last);
        check({tag, " valid"}, 64'(out_valid), 64'd1);
        check({tag, " vec"},   out_vec,        vec);
        check({tag, " addr"},  64'(out_addr),  64'(addr));
        check({tag, " end"},   64'(out_end),   64'(last));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " valid"}, 64'(out_valid), 64'd0);
        check({tag, " vec"},   out_vec,        64'd0);
        check({tag, " addr"},  64'(out_addr),  64'd0);
        check({tag, " end"},   64'(out_end),   64'd0);
    endtask

    task automatic start_req(input logic [15:0] cnt, input logic [15:0] nw, input logic [31:0] addr);
        in_count  = cnt;
        in_nwords = nw;
        in_addr   = addr;
        in_valid  = 1'b1;
        check("in_ready before accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        start_req(v.count, v.nwords, v.addr);
        for (int k = 0; k < int'(v.n); k++) begin
            tag = $sformatf("vec%0d w%0d", idx, k);
            check_word(tag, v.exp[k], v.addr + 32'(k), k == int'(v.n) - 1);
            tick();
        end
        check($sformatf("vec%0d drop valid", idx), 64'(out_valid), 64'd0);
    endtask

    function automatic vec_t mk(input logic [15:0] cnt, input logic [15:0] nw,
                                input logic [31:0] addr, input logic [2:0] n,
                                input logic [63:0] w0, input logic [63:0] w1,
                                input logic [63:0] w2);
        vec_t v;
        v.count  = cnt;
        v.nwords = nw;
        v.addr   = addr;
        v.n      = n;
        v.exp    = {w2, w1, w0};
        return v;
    endfunction

    vec_t vecs [7];

    initial begin
        vecs[0] = mk(16'd70,  16'd3, 32'h10,       3'd3, ONES,  64'h3F, 64'h0);
        vecs[1] = mk(16'd64,  16'd2, 32'h20,       3'd2, ONES,  64'h0,  64'h0);
        vecs[2] = mk(16'd0,   16'd1, 32'h30,       3'd1, 64'h0, 64'h0,  64'h0);
        vecs[3] = mk(16'd500, 16'd2, 32'h40,       3'd2, ONES,  ONES,   64'h0);
        vecs[4] = mk(16'd5,   16'd0, 32'h50,       3'd1, 64'h1F, 64'h0, 64'h0);
        vecs[5] = mk(16'd130, 16'd3, 32'hFFFF_FFFF, 3'd3, ONES, ONES,   64'h3);
        vecs[6] = mk(16'd1,   16'd1, 32'h58,       3'd1, 64'h1, 64'h0,  64'h0);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_count  = '0;
        in_nwords = '0;
        in_addr   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: word0 must hold for three stalled cycles.
        out_ready = 1'b0;
        start_req(16'd100, 16'd2, 32'h60);
        for (int c = 0; c < 3; c++) begin
            check_word($sformatf("bp stall%0d", c), ONES, 32'h60, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        check_word("bp w0 release", ONES, 32'h60, 1'b0);
        tick();
        check_word("bp w1", 64'hF_FFFF_FFFF, 32'h61, 1'b1);
        tick();
        check("bp drop valid", 64'(out_valid), 64'd0);

        // Reset during word1 of a 4-word request.
        start_req(16'd256, 16'd4, 32'h70);
        check_word("rst w0", ONES, 32'h70, 1'b0);
        tick();
        check_word("rst w1", ONES, 32'h71, 1'b0);
        rst = 1'b1;
        tick();
        check_idle_outputs("rst mid");
        check("rst mid in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst release in_ready", 64'(in_ready), 64'd1);
        tick();
        check_idle_outputs("rst no resume");

        // Back-to-back: second request held valid throughout, one bubble expected.
        start_req(16'd3, 16'd2, 32'h80);
        in_count  = 16'd65;
        in_nwords = 16'd2;
        in_addr   = 32'h90;
        in_valid  = 1'b1;
        check_word("b2b A w0", 64'h7, 32'h80, 1'b0);
        check("b2b busy in_ready", 64'(in_ready), 64'd0);
        tick();
        check_word("b2b A w1", 64'h0, 32'h81, 1'b1);
        tick();
        check("b2b bubble valid", 64'(out_valid), 64'd0);
        check("b2b bubble in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_word("b2b B w0", ONES, 32'h90, 1'b0);
        tick();
        check_word("b2b B w1", 64'h1, 32'h91, 1'b1);
        tick();
        check("b2b drop valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
